shadow_stack_ctrl: RTL

Sequencer and checker sitting between the commit stage and the return-address shadow stack (register LIFO with push/pop, zero-latency top/full/empty).
- Takes committed call/return events through a valid/ready handshake.
- Turns each event into legal single-operation stack pushes and pops, and checks return targets against the stack top.
- Raises a sticky violation to the CSR/exception logic.
- Drains the stack on a flush request.

---
 rtl/ss_pkg.sv | 36 +++
 rtl/shadow_stack_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ss_pkg.sv
// ss_pkg: shared types for the return-address shadow stack controller
package ss_pkg;

    localparam int SS_ADDR_W = 64;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_CALL = 2'd1,
        EVT_RET  = 2'd2,
        EVT_SWAP = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_MISMATCH  = 2'd1,
        CAUSE_UNDERFLOW = 2'd2,
        CAUSE_OVERFLOW  = 2'd3
    } viol_cause_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SWAP_PUSH = 2'd1,
        ST_VIOL      = 2'd2,
        ST_DRAIN     = 2'd3
    } ctrl_state_e;

    // Address fields are sized for the widest supported stack; narrower
    // instances zero-extend on capture and truncate on use.
    typedef struct packed {
        logic                 valid;
        evt_type_e            typ;
        logic [SS_ADDR_W-1:0] addr;
        logic [SS_ADDR_W-1:0] link;
    } evt_t;

endpackage

// File: rtl/shadow_stack_ctrl.sv
// shadow_stack_ctrl: sequences call/return events into shadow stack ops and checks return targets
module shadow_stack_ctrl
    import ss_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DEPTH     = 16,
    parameter int DROP_W    = 8,
    parameter bit OVF_FATAL = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_evt_valid,
    output logic              o_evt_ready,
    input  logic [1:0]        i_evt_type,
    input  logic [ADDR_W-1:0] i_evt_addr,
    input  logic [ADDR_W-1:0] i_evt_link,
    output logic              o_stk_push,
    output logic [ADDR_W-1:0] o_stk_data,
    output logic              o_stk_pop,
    input  logic [ADDR_W-1:0] i_stk_data,
    input  logic              i_stk_full,
    input  logic              i_stk_empty,
    output logic              o_viol,
    output logic [1:0]        o_viol_cause,
    output logic [ADDR_W-1:0] o_viol_expected,
    output logic [ADDR_W-1:0] o_viol_target,
    input  logic              i_viol_clear,
    output logic [DROP_W-1:0] o_drop_cnt,
    output logic              o_busy
);

    if (ADDR_W > SS_ADDR_W || DROP_W < $clog2(DEPTH + 1)) begin : g_param_check
        $error("shadow_stack_ctrl: ADDR_W too wide or DROP_W too narrow for DEPTH");
    end

    ctrl_state_e       state, state_n;
    evt_t              evt_q;
    logic [DROP_W-1:0] drop_cnt, drop_n;
    logic              exec_viol;
    viol_cause_e       cause_q, cause_n;
    logic [ADDR_W-1:0] exp_q, exp_n, tgt_q, tgt_n;
    logic [ADDR_W-1:0] q_addr, q_link, call_data;
    logic              ret_step, call_step;

    assign q_addr    = ADDR_W'(evt_q.addr);
    assign q_link    = ADDR_W'(evt_q.link);
    assign ret_step  = state == ST_RUN && evt_q.valid && (evt_q.typ == EVT_RET || evt_q.typ == EVT_SWAP);
    assign call_step = (state == ST_RUN && evt_q.valid && evt_q.typ == EVT_CALL) || state == ST_SWAP_PUSH;
    assign call_data = state == ST_SWAP_PUSH ? q_link : q_addr;

    assign o_evt_ready     = state == ST_RUN && !exec_viol && !(evt_q.valid && evt_q.typ == EVT_SWAP);
    assign o_viol          = state == ST_VIOL;
    assign o_viol_cause    = cause_q;
    assign o_viol_expected = exp_q;
    assign o_viol_target   = tgt_q;
    assign o_drop_cnt      = drop_cnt;
    assign o_busy          = state == ST_SWAP_PUSH || state == ST_DRAIN;

    // Execute step, violation detect and next state; at most one stack op per cycle
    always_comb begin
        state_n    = state;
        o_stk_push = 1'b0;
        o_stk_pop  = 1'b0;
        o_stk_data = '0;
        drop_n     = drop_cnt;
        exec_viol  = 1'b0;
        cause_n    = CAUSE_NONE;
        exp_n      = '0;
        tgt_n      = '0;
        if (ret_step) begin
            if (|drop_cnt) begin
                drop_n = drop_cnt - 1'b1;
            end else if (i_stk_empty) begin
                exec_viol = 1'b1;
                cause_n   = CAUSE_UNDERFLOW;
                tgt_n     = q_addr;
            end else if (i_stk_data == q_addr) begin
                o_stk_pop = 1'b1;
            end else begin
                exec_viol = 1'b1;
                cause_n   = CAUSE_MISMATCH;
                exp_n     = i_stk_data;
                tgt_n     = q_addr;
            end
            if (!exec_viol && evt_q.typ == EVT_SWAP) state_n = ST_SWAP_PUSH;
        end
        if (call_step) begin
            if (!i_stk_full) begin
                o_stk_push = 1'b1;
                o_stk_data = call_data;
            end else if (OVF_FATAL) begin
                exec_viol = 1'b1;
                cause_n   = CAUSE_OVERFLOW;
                exp_n     = i_stk_data;
                tgt_n     = call_data;
            end else begin
                drop_n = &drop_cnt ? drop_cnt : drop_cnt + 1'b1;
            end
            if (state == ST_SWAP_PUSH) state_n = ST_RUN;
        end
        if (exec_viol) state_n = ST_VIOL;
        if (state == ST_VIOL && i_viol_clear) state_n = ST_RUN;
        if (state == ST_DRAIN) begin
            o_stk_pop = !i_stk_empty;
            state_n   = i_stk_empty ? ST_RUN : ST_DRAIN;
        end
        if (i_flush) begin
            state_n = ST_DRAIN;
            drop_n  = '0;
        end
    end

    // State and drop counter registers
    always_ff @(posedge clk) begin
        state    <= !rstn ? ST_RUN : state_n;
        drop_cnt <= !rstn ? '0 : drop_n;
    end

    // Event slot: capture on handshake, hold through the SWAP push cycle, else retire
    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            evt_q <= '0;
        end else if (o_evt_ready && i_evt_valid) begin
            evt_q.valid <= i_en;
            evt_q.typ   <= evt_type_e'(i_evt_type);
            evt_q.addr  <= SS_ADDR_W'(i_evt_addr);
            evt_q.link  <= SS_ADDR_W'(i_evt_link);
        end else if (state_n != ST_SWAP_PUSH) begin
            evt_q.valid <= 1'b0;
        end
    end

    // Violation details latch on entry to VIOL and hold until cleared or flushed
    always_ff @(posedge clk) begin
        if (!rstn || i_flush || (state == ST_VIOL && i_viol_clear)) begin
            cause_q <= CAUSE_NONE;
            exp_q   <= '0;
            tgt_q   <= '0;
        end else if (state != ST_VIOL && state_n == ST_VIOL) begin
            cause_q <= cause_n;
            exp_q   <= exp_n;
            tgt_q   <= tgt_n;
        end
    end

endmodule
